// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite RAM read arbiter.
// Pipeline tags are sized for the largest supported requester count.
package sprite_arb_pkg;

   localparam int unsigned SPRITE_W_DEF = 50;
   localparam int unsigned SPRITE_H_DEF = 50;
   localparam int unsigned ADDR_W_DEF   = 19;
   localparam int unsigned MAX_REQ      = 8;

   typedef logic [5:0] coord_t;

   typedef struct packed {
      logic               valid;
      logic [MAX_REQ-1:0] tag;
      logic               oob;
   } pipe_entry_t;

endpackage

// File: rtl/sprite_read_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker
   import sprite_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
         if (!any && req[idx]) begin
            winner[idx] = 1'b1;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_read_arbiter.sv
// Round-robin arbiter sharing one registered sprite RAM read port; responses
// return tagged two cycles after grant. Optional SPRITE_MIRROR_EN adds req_mirror.
module sprite_read_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned SPRITE_W  = SPRITE_W_DEF,
   parameter int unsigned SPRITE_H  = SPRITE_H_DEF,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*6-1:0]  req_row,
   input  logic [NUM_REQ*6-1:0]  req_col,
`ifdef SPRITE_MIRROR_EN
   input  logic [NUM_REQ-1:0]    req_mirror,
`endif
   output logic [NUM_REQ-1:0]    gnt,
   output logic [ADDR_W-1:0]     ram_read_address,
   input  logic [DATA_W-1:0]     ram_data_Out,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DATA_W-1:0]     rsp_data
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   ptr_next;
   logic [NUM_REQ-1:0] winner;
   logic               any;
   coord_t             sel_row;
   coord_t             sel_col;
   coord_t             eff_col;
   logic               oob;
   logic [ADDR_W-1:0]  lin_addr;
   pipe_entry_t        s1_next;
   pipe_entry_t        s1;
   pipe_entry_t        s2;
   logic               unused_tag;
`ifdef SPRITE_MIRROR_EN
   logic               sel_mirror;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      win_idx = '0;
      sel_row = '0;
      sel_col = '0;
`ifdef SPRITE_MIRROR_EN
      sel_mirror = 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            win_idx = PTR_W'(i);
            sel_row = req_row[i*6 +: 6];
            sel_col = req_col[i*6 +: 6];
`ifdef SPRITE_MIRROR_EN
            sel_mirror = req_mirror[i];
`endif
         end
      end
   end

   // Range check uses the raw column; mirroring only affects in-range addresses.
   always_comb begin
      oob = (32'(sel_row) >= SPRITE_H) || (32'(sel_col) >= SPRITE_W);
`ifdef SPRITE_MIRROR_EN
      eff_col = sel_mirror ? (coord_t'(SPRITE_W - 1) - sel_col) : sel_col;
`else
      eff_col = sel_col;
`endif
      lin_addr = oob ? ADDR_W'(BASE_ADDR)
                     : ADDR_W'(BASE_ADDR) + ADDR_W'(sel_row) * ADDR_W'(SPRITE_W)
                       + ADDR_W'(eff_col);
      ptr_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      s1_next       = '0;
      s1_next.valid = any;
      s1_next.tag   = MAX_REQ'(winner);
      s1_next.oob   = any & oob;
   end

   assign unused_tag = ^s2.tag;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         gnt              <= '0;
         ptr              <= '0;
         ram_read_address <= ADDR_W'(BASE_ADDR);
         s1               <= '0;
         s2               <= '0;
         rsp_valid        <= '0;
         rsp_data         <= '0;
      end else begin
         gnt <= winner;
         s1  <= s1_next;
         s2  <= s1;
         if (any) begin
            ptr              <= ptr_next;
            ram_read_address <= lin_addr;
         end
         rsp_valid <= s2.valid ? s2.tag[NUM_REQ-1:0] : '0;
         // rsp_data holds through idle cycles; only a live entry updates it.
         if (s2.valid)
            rsp_data <= s2.oob ? '0 : ram_data_Out;
      end
   end

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Self-checking bench for sprite_read_arbiter: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_sprite_read_arbiter;

   localparam int N = 4;
`ifdef SPRITE_MIRROR_EN
   localparam bit MIR = 1'b1;
`else
   localparam bit MIR = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic [3:0]  req;
   logic [23:0] req_row, req_col;
   logic [3:0]  req_mirror;
   logic [3:0]  gnt, gnt2, rsp_valid, rsp_valid2;
   logic [18:0] addr, addr2;
   logic [4:0]  ram_q, ram_q2, rsp_data, rsp_data2;
   logic [4:0]  mem [0:8191];

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      ram_q  <= mem[addr[12:0]];
      ram_q2 <= mem[addr2[12:0]];
   end

   sprite_read_arbiter #(
      .NUM_REQ(4), .SPRITE_W(50), .SPRITE_H(50), .BASE_ADDR(0), .ADDR_W(19), .DATA_W(5)
   ) u_dut (
      .Clk(Clk), .Reset(Reset), .req(req), .req_row(req_row), .req_col(req_col),
`ifdef SPRITE_MIRROR_EN
      .req_mirror(req_mirror),
`endif
      .gnt(gnt), .ram_read_address(addr), .ram_data_Out(ram_q),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   sprite_read_arbiter #(
      .NUM_REQ(4), .SPRITE_W(50), .SPRITE_H(50), .BASE_ADDR(2500), .ADDR_W(19), .DATA_W(5)
   ) u_base (
      .Clk(Clk), .Reset(Reset), .req(req), .req_row(req_row), .req_col(req_col),
`ifdef SPRITE_MIRROR_EN
      .req_mirror(req_mirror),
`endif
      .gnt(gnt2), .ram_read_address(addr2), .ram_data_Out(ram_q2),
      .rsp_valid(rsp_valid2), .rsp_data(rsp_data2)
   );

   typedef struct {
      int   due;
      logic [3:0] tag;
      bit   oob;
      int   addr;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      int   row;
      int   col;
      bit   mir;
      logic [3:0] gnt;
      int   addr;
      int   addr2;
      int   data;
   } vec_t;

   exp_t       exp_q[$];
   vec_t       tbl[$];
   int         m_ptr, m_edge, m_last;
   logic [3:0] m_gnt;
   int         checks, failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_edge);
      end
   endtask

   task automatic set_all(input int row, input int col, input bit mir);
      for (int i = 0; i < N; i++) begin
         req_row[i*6 +: 6] = 6'(row);
         req_col[i*6 +: 6] = 6'(col);
         req_mirror[i]     = mir;
      end
   endtask

   // Predicts one clock edge from the rules, then compares after the edge.
   task automatic step();
      logic [3:0] e_gnt, e_rv;
      int e_addr, e_rd;
      bit granted;
      m_edge++;
      e_gnt = '0; e_rv = '0; e_rd = m_last; e_addr = 0; granted = 1'b0;
      if (Reset) begin
         m_ptr = 0; m_last = 0; e_rd = 0;
         exp_q.delete();
         granted = 1'b1;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].due == m_edge) begin
            e_rv   = exp_q[0].tag;
            e_rd   = exp_q[0].oob ? 0 : int'(mem[exp_q[0].addr]);
            m_last = e_rd;
            void'(exp_q.pop_front());
         end
         for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (!granted && req[idx]) begin
               int r = int'(req_row[idx*6 +: 6]);
               int c = int'(req_col[idx*6 +: 6]);
               bit o = (r >= 50) || (c >= 50);
               int cc = (MIR && req_mirror[idx]) ? 49 - c : c;
               granted    = 1'b1;
               e_gnt[idx] = 1'b1;
               m_ptr      = (idx + 1) % N;
               e_addr     = o ? 0 : r * 50 + cc;
               exp_q.push_back('{m_edge + 2, e_gnt, o, e_addr});
            end
         end
      end
      m_gnt = e_gnt;
      @(posedge Clk);
      #1;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_data", 32'(rsp_data), e_rd);
      if (granted) begin
         chk("addr", 32'(addr), e_addr);
         chk("addr_base2500", 32'(addr2), e_addr + 2500);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      req   = '0;
      step();
      Reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0;
      m_ptr = 0; m_edge = 0; m_last = 0; m_gnt = '0;
      Reset = 1'b1; req = '0; req_row = '0; req_col = '0; req_mirror = '0;
      for (int i = 0; i < 8192; i++) mem[i] = 5'($urandom);
      mem[103] = 5'd5; mem[0] = 5'd7; mem[2499] = 5'd3; mem[51] = 5'd6;
      mem[199] = 5'd2; mem[99] = 5'd4; mem[50] = 5'd1;

      //            req      row col mir gnt      addr  addr2 data
      tbl.push_back('{4'b0001, 2,  3,  0, 4'b0001, 103,  2603, 5});
      tbl.push_back('{4'b0010, 0,  50, 0, 4'b0010, 0,    2500, 0});
      tbl.push_back('{4'b0100, 49, 49, 0, 4'b0100, 2499, 4999, 3});
      tbl.push_back('{4'b0100, 50, 0,  0, 4'b0100, 0,    2500, 0});
      tbl.push_back('{4'b1010, 1,  1,  0, 4'b0010, 51,   2551, 6});
      tbl.push_back('{4'b1000, 3,  49, 0, 4'b1000, 199,  2699, 2});
`ifdef SPRITE_MIRROR_EN
      tbl.push_back('{4'b0001, 1,  0,  1, 4'b0001, 99,   2599, 4});
      tbl.push_back('{4'b0001, 1,  0,  0, 4'b0001, 50,   2550, 1});
`endif

      do_reset();
      chk("reset_gnt", 32'(gnt), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_data", 32'(rsp_data), 0);
      chk("reset_addr", 32'(addr), 0);

      foreach (tbl[v]) begin
         do_reset();
         set_all(tbl[v].row, tbl[v].col, tbl[v].mir);
         req = tbl[v].req;
         step();
         chk("tbl_gnt", 32'(gnt), 32'(tbl[v].gnt));
         chk("tbl_addr", 32'(addr), tbl[v].addr);
         chk("tbl_addr2", 32'(addr2), tbl[v].addr2);
         req = '0;
         step();
         chk("tbl_rsp_early", 32'(rsp_valid), 0);
         step();
         chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[v].gnt));
         chk("tbl_rsp_data", 32'(rsp_data), tbl[v].data);
         step();
         chk("tbl_rsp_hold", 32'(rsp_data), tbl[v].data);
      end

      // All four requesting continuously: strict rotation 0,1,2,3,...
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_row[i*6 +: 6] = 6'($urandom_range(0, 49));
         req_col[i*6 +: 6] = 6'($urandom_range(0, 49));
      end
      req_mirror = '0;
      req = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("rotate_gnt", 32'(gnt), 32'(1) << (k % 4));
      end
      req = '0;
      step(); step(); step();

      // Single requester back-to-back.
      do_reset();
      set_all(5, 7, 1'b0);
      req = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("single_gnt", 32'(gnt), 1);
      end
      req = '0;
      step(); step(); step();

      // Reset one cycle after a grant discards the in-flight response.
      do_reset();
      set_all(2, 3, 1'b0);
      req = 4'b0011;
      step();
      chk("rst_mid_gnt", 32'(gnt), 1);
      req = 4'b0011;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      chk("rst_mid_rv_t2", 32'(rsp_valid), 0);
      chk("rst_mid_ptr", 32'(gnt), 1);
      step();
      chk("rst_mid_rv_t3", 32'(rsp_valid), 0);
      req = '0;
      step(); step(); step();

      // Randomized legal traffic; requesters only change after their grant.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] || m_gnt[i]) begin
               req[i]            = ($urandom_range(0, 2) != 0);
               req_row[i*6 +: 6] = 6'($urandom_range(0, 55));
               req_col[i*6 +: 6] = 6'($urandom_range(0, 55));
               req_mirror[i]     = 1'($urandom);
            end
         end
         Reset = ($urandom_range(0, 39) == 0);
         step();
      end
      Reset = 1'b0;
      req   = '0;
      step(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
